// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter.
//   state_t     : host-to-device transfer FSM states
//   DATA_BITS   : data bits per PS/2 frame
//   FRAME_EDGES : device clock falling edges per host-to-device frame
//                 (8 data + parity + stop + ack)
//   odd_parity  : parity bit that makes the frame's count of ones odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_ACK,
    WAIT_IDLE
  } state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned FRAME_EDGES = 11;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] i_d);
    return ~^i_d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- 2-flop synchronizer with falling-edge detect for one
// PS/2 pad line.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_async    : raw pad level (asynchronous)
//   o_sync     : synchronized level
//   o_fall     : one-cycle pulse on a synchronized 1->0 transition
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to 1: an idle PS/2 line floats high, so leaving reset
  // must not fabricate a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   tx_data/tx_valid   : command byte and request (accepted when tx_ready=1)
//   tx_ready           : idle, request can be accepted
//   ps2_clk_i/data_i   : raw pad inputs (asynchronous)
//   ps2_clk_oe/data_oe : 1 = pull the line low (open-drain enables)
//   done               : one-cycle pulse at the end of a transfer
//   ack_ok             : device acknowledge, held until the next done
//   err_timeout        : pulses with done when the watchdog aborts
// Build option: define PS2_HOST_TX_TIMEOUT_EN to add the transfer watchdog
// (TIMEOUT_US, counted from entry to RTS). Without it err_timeout is 0 and
// the block waits on the device indefinitely.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned INHIBIT_CYC =
    32'((64'(INHIBIT_US) * 64'(CLK_FREQ_HZ)) / 64'd1_000_000);
  localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

  localparam int unsigned BIT_W   = $clog2(FRAME_EDGES);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] PAR_IDX = BIT_W'(DATA_BITS);

  if (INHIBIT_CYC == 0 || TIMEOUT_US == 0) begin : g_bad_cfg
    $error("ps2_host_tx: INHIBIT_US and TIMEOUT_US must be non-zero");
  end

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ps2_clk_i),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ps2_data_i),
    .o_sync (w_data_sync),
    .o_fall (w_data_fall)
  );

  state_t           r_state;
  logic [7:0]       r_data;
  logic [INH_W-1:0] r_inh_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_ready;
  logic             r_done;
  logic             r_ack;
  logic             r_ack_ok;
  logic             w_complete;

  assign w_complete = (r_state == WAIT_IDLE) && w_clk_sync && w_data_sync;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC =
    32'((64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ)) / 64'd1_000_000);
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic            w_wd_active;

  assign w_wd_active = (r_state == RTS) || (r_state == SHIFT) ||
                       (r_state == WAIT_ACK) || (r_state == WAIT_IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_inh_cnt <= '0;
      r_bit_cnt <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_ack     <= 1'b0;
      r_ack_ok  <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      r_wd_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_ready   <= 1'b1;
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (tx_valid && r_ready) begin
            r_data    <= tx_data;
            r_ready   <= 1'b0;
            r_clk_oe  <= 1'b1;
            r_inh_cnt <= '0;
            r_state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_inh_cnt <= '0;
            r_data_oe <= 1'b1;
            r_state   <= RTS;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        RTS: begin
          r_clk_oe  <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          // r_bit_cnt = falling edges already seen; it tops out at 10.
          if (w_clk_fall) begin
            if (r_bit_cnt < PAR_IDX) begin
              r_data_oe <= ~r_data[r_bit_cnt[IDX_W-1:0]];
            end else if (r_bit_cnt == PAR_IDX) begin
              r_data_oe <= ~odd_parity(r_data);
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= WAIT_ACK;
            end
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (w_clk_fall) begin
            r_ack   <= ~w_data_sync;
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (w_complete) begin
            r_done    <= 1'b1;
            r_ack_ok  <= r_ack;
            r_ready   <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Watchdog overrides the FSM, but a transfer completing on the
      // expiry cycle still counts as completed.
      if (w_wd_active) begin
        if (r_wd_cnt == WD_LAST && !w_complete) begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_done    <= 1'b1;
          r_err     <= 1'b1;
          r_ack_ok  <= 1'b0;
          r_ready   <= 1'b1;
          r_bit_cnt <= '0;
          r_wd_cnt  <= '0;
          r_state   <= IDLE;
        end else if (r_wd_cnt != WD_LAST) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
`endif
    end
  end

  // Gating with rst_n releases the lines the moment reset asserts.
  assign ps2_clk_oe  = r_clk_oe & rst_n;
  assign ps2_data_oe = r_data_oe & rst_n;
  assign tx_ready    = r_ready;
  assign done        = r_done;
  assign ack_ok      = r_ack_ok;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT_US = 50;
`else
  localparam int unsigned TB_TIMEOUT_US = 15000;
`endif
  localparam int unsigned HALF = 20;  // device clock half period, sys cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;

  logic dev_clk;
  logic dev_data;

  // Wired-AND of device drive and host pull-down.
  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ(100_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (TB_TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .ack_ok     (ack_ok),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [9:0] frame;      // {stop, parity, data[7:0]} as seen on the line
    logic       ack;
    logic       err;
    bit         chk_frame;
  } exp_t;

  exp_t sb[$];

  int unsigned n_tests = 0;
  int unsigned n_fails = 0;
  int unsigned done_seen = 0;
  int unsigned inh_cnt = 0;
  int unsigned inhibit_len = 0;
  logic [9:0]  dev_frame;
  logic        dev_start;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Length of the clock-inhibit phase before the start bit.
  always @(negedge clk) begin
    if (!ps2_clk_oe) inh_cnt = 0;
    else if (!ps2_data_oe) inh_cnt++;
    else if (inh_cnt != 0) begin
      inhibit_len = inh_cnt;
      inh_cnt = 0;
    end
  end

  // Monitor: every done pulse is matched against the next expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_ok", ack_ok, e.ack);
        check("err_timeout", err_timeout, e.err);
        check("clk_oe_at_done", ps2_clk_oe, 1'b0);
        check("data_oe_at_done", ps2_data_oe, 1'b0);
        if (e.chk_frame) begin
          check("frame", dev_frame, e.frame);
          check("start_bit", dev_start, 1'b0);
          check("inhibit_cycles", inhibit_len, 32'd10000);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int unsigned n = 0;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned prev, input int unsigned bound);
    int unsigned n = 0;
    while (done_seen == prev && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_seen, prev + 1);
  endtask

  // Device model: waits for the start bit, then clocks n_edges falling
  // edges, sampling the line 3 cycles after each one. Edge 11 carries the
  // acknowledge (data pulled low) when do_ack is set.
  task automatic dev_xfer(input int unsigned n_edges, input bit do_ack);
    int unsigned n = 0;
    dev_frame = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", ps2_data_oe && !ps2_clk_oe, 1'b1);
    repeat (10) @(negedge clk);
    dev_start = ps2_data_i;
    for (int unsigned k = 1; k <= n_edges; k++) begin
      if (k == 11 && do_ack) begin
        dev_data = 1'b0;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      if (k <= 10) dev_frame[k-1] = ps2_data_i;
      repeat (HALF - 3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  initial begin
    int unsigned d0;
    rst_n    = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1'b1);

    // 0xF4, acked: bits 0,0,1,0,1,1,1,1, parity 0, stop 1
    sb.push_back('{frame: 10'h2F4, ack: 1'b1, err: 1'b0, chk_frame: 1'b1});
    d0 = done_seen;
    send(8'hF4);
    dev_xfer(11, 1'b1);
    wait_done(d0, 500);
    repeat (100) @(negedge clk);
    check("ack_ok_hold_1", ack_ok, 1'b1);

    // 0xFF, acked: parity 1
    sb.push_back('{frame: 10'h3FF, ack: 1'b1, err: 1'b0, chk_frame: 1'b1});
    d0 = done_seen;
    send(8'hFF);
    dev_xfer(11, 1'b1);
    wait_done(d0, 500);

    // 0x3C, not acked, with a 0x00 request pulsed while busy
    sb.push_back('{frame: 10'h33C, ack: 1'b0, err: 1'b0, chk_frame: 1'b1});
    d0 = done_seen;
    send(8'h3C);
    repeat (50) @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_while_busy", tx_ready, 1'b0);
    dev_xfer(11, 1'b0);
    wait_done(d0, 500);
    repeat (300) @(negedge clk);
    check("no_second_xfer", ps2_clk_oe, 1'b0);
    check("no_extra_done", done_seen, d0 + 1);
    check("ack_ok_hold_0", ack_ok, 1'b0);

    // Reset during the inhibit phase releases the clock line at once
    send(8'hF4);
    repeat (200) @(negedge clk);
    check("inhibit_clk_oe", ps2_clk_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_inh_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_inh_data_oe", ps2_data_oe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after the 4th bit (0xF4 bit3 = 0, so data is pulled low)
    send(8'hF4);
    dev_xfer(4, 1'b0);
    check("bit4_data_oe", ps2_data_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_mid_data_oe", ps2_data_oe, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_mid_ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", tx_ready, 1'b1);

    // Fresh 0xF4 after the aborted one
    sb.push_back('{frame: 10'h2F4, ack: 1'b1, err: 1'b0, chk_frame: 1'b1});
    d0 = done_seen;
    send(8'hF4);
    dev_xfer(11, 1'b1);
    wait_done(d0, 500);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Silent device: watchdog aborts TB_TIMEOUT_US after RTS
    sb.push_back('{frame: 10'h000, ack: 1'b0, err: 1'b1, chk_frame: 1'b0});
    d0 = done_seen;
    send(8'hA5);
    wait_done(d0, 10000 + TB_TIMEOUT_US * 100 + 500);
`endif

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
